// File: rtl/alarm_clock_multi_if.sv
// Control and status bundle for alarm_clock_multi: set-mode controls, alarm
// arming and snooze in, time/display/alarm status out.
interface alarm_clock_multi_if #(
    parameter int NA = 2,
    parameter int CW = 7
);
    localparam int SW = (NA > 1) ? $clog2(NA) : 1;

    logic          tick;
    logic          timeset;
    logic          alarmset;
    logic [SW-1:0] alm_sel;
    logic          minadv;
    logic          hrsadv;
    logic          dayadv;
    logic [NA-1:0] alm_en;
    logic          alarm_on;
    logic          snooze;

    logic [CW-1:0] t_sec;
    logic [CW-1:0] t_min;
    logic [CW-1:0] t_hrs;
    logic [CW-1:0] t_day;
    logic [CW-1:0] disp_min;
    logic [CW-1:0] disp_hrs;
    logic          pm;
    logic          buzz;
    logic [SW-1:0] ring_idx;
    logic          snoozing;

    modport master (
        output tick, timeset, alarmset, alm_sel, minadv, hrsadv, dayadv,
               alm_en, alarm_on, snooze,
        input  t_sec, t_min, t_hrs, t_day, disp_min, disp_hrs, pm, buzz,
               ring_idx, snoozing
    );

    modport slave (
        input  tick, timeset, alarmset, alm_sel, minadv, hrsadv, dayadv,
               alm_en, alarm_on, snooze,
        output t_sec, t_min, t_hrs, t_day, disp_min, disp_hrs, pm, buzz,
               ring_idx, snoozing
    );
endinterface

// File: rtl/alarm_clock_multi.sv
// Day-of-week clock with NA alarm slots and a ring/snooze/timeout FSM.
// Optional macro TWELVE_HR_EN switches disp_hrs/pm to 12-hour presentation.
module alarm_clock_multi #(
    parameter int NS         = 60,
    parameter int NH         = 24,
    parameter int ND         = 7,
    parameter int NA         = 2,
    parameter int CW         = 7,
    parameter int SNOOZE_SEC = 540,
    parameter int RING_SEC   = 60
) (
    input  logic              clk,
    input  logic              rst,
    alarm_clock_multi_if.slave bus
);
    localparam int SW   = (NA > 1) ? $clog2(NA) : 1;
    localparam int CMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
    localparam int KW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    // ---------------- time of day ----------------
    logic [CW-1:0] sec_reg, min_reg, hrs_reg, day_reg;
    logic [CW-1:0] sec_next, min_next, hrs_next, day_next;
    logic          sec_wrap, min_wrap, hrs_wrap, day_wrap;
    logic [CW-1:0] sec_inc, min_inc, hrs_inc, day_inc;

    assign sec_wrap = (sec_reg == CW'(NS - 1));
    assign min_wrap = (min_reg == CW'(NS - 1));
    assign hrs_wrap = (hrs_reg == CW'(NH - 1));
    assign day_wrap = (day_reg == CW'(ND - 1));
    assign sec_inc  = sec_wrap ? '0 : sec_reg + CW'(1);
    assign min_inc  = min_wrap ? '0 : min_reg + CW'(1);
    assign hrs_inc  = hrs_wrap ? '0 : hrs_reg + CW'(1);
    assign day_inc  = day_wrap ? '0 : day_reg + CW'(1);

    // In time-set mode each field advances on its own, with no carries.
    always_comb begin
        sec_next = sec_reg;
        min_next = min_reg;
        hrs_next = hrs_reg;
        day_next = day_reg;
        if (bus.tick) begin
            if (bus.timeset) begin
                if (bus.minadv) min_next = min_inc;
                if (bus.hrsadv) hrs_next = hrs_inc;
                if (bus.dayadv) day_next = day_inc;
            end else begin
                sec_next = sec_inc;
                if (sec_wrap) begin
                    min_next = min_inc;
                    if (min_wrap) begin
                        hrs_next = hrs_inc;
                        if (hrs_wrap) day_next = day_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sec_reg <= '0;
            min_reg <= '0;
            hrs_reg <= '0;
            day_reg <= '0;
        end else begin
            sec_reg <= sec_next;
            min_reg <= min_next;
            hrs_reg <= hrs_next;
            day_reg <= day_next;
        end
    end

    // ---------------- alarm slots ----------------
    logic [NA-1:0][CW-1:0] amin_all;
    logic [NA-1:0][CW-1:0] ahrs_all;
    logic [NA-1:0]         match_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NA; gi++) begin : g_slot
            logic [CW-1:0] amin_reg, ahrs_reg;
            logic          wr_en;

            assign wr_en = bus.tick && bus.alarmset && !bus.timeset &&
                           (32'(bus.alm_sel) == gi);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    amin_reg <= '0;
                    ahrs_reg <= '0;
                end else if (wr_en) begin
                    if (bus.minadv)
                        amin_reg <= (amin_reg == CW'(NS - 1)) ? '0 : amin_reg + CW'(1);
                    if (bus.hrsadv)
                        ahrs_reg <= (ahrs_reg == CW'(NH - 1)) ? '0 : ahrs_reg + CW'(1);
                end
            end

            assign amin_all[gi]  = amin_reg;
            assign ahrs_all[gi]  = ahrs_reg;
            assign match_vec[gi] = bus.alarm_on && bus.alm_en[gi] && (sec_reg == '0) &&
                                   (min_reg == amin_reg) && (hrs_reg == ahrs_reg);
        end
    endgenerate

    // Lowest-numbered matching slot wins.
    logic          hit_any;
    logic [SW-1:0] hit_idx;
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NA - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                hit_any = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    // ---------------- ring / snooze FSM ----------------
    logic          sec_upd_reg;
    logic          snooze_q_reg;
    logic          snooze_rise;
    state_t        state_reg, state_next;
    logic [KW-1:0] cnt_reg, cnt_next;
    logic [SW-1:0] idx_reg, idx_next;
    logic          buzz_reg, snoozing_reg;

    assign snooze_rise = bus.snooze && !snooze_q_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        if (!bus.alarm_on) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sec_upd_reg && hit_any) begin
                        state_next = RINGING;
                        cnt_next   = KW'(RING_SEC);
                        idx_next   = hit_idx;
                    end
                end
                RINGING: begin
                    if (snooze_rise) begin
                        state_next = SNOOZE;
                        cnt_next   = KW'(SNOOZE_SEC);
                    end else if (bus.tick) begin
                        cnt_next = cnt_reg - KW'(1);
                        if (cnt_reg == KW'(1)) state_next = IDLE;
                    end
                end
                SNOOZE: begin
                    if (bus.tick) begin
                        cnt_next = cnt_reg - KW'(1);
                        if (cnt_reg == KW'(1)) begin
                            state_next = RINGING;
                            cnt_next   = KW'(RING_SEC);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // buzz/snoozing are registered copies of the state they decode.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            sec_upd_reg  <= 1'b0;
            snooze_q_reg <= 1'b0;
            buzz_reg     <= 1'b0;
            snoozing_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            sec_upd_reg  <= bus.tick;
            snooze_q_reg <= bus.snooze;
            buzz_reg     <= (state_next == RINGING);
            snoozing_reg <= (state_next == SNOOZE);
        end
    end

    // ---------------- outputs ----------------
    logic          sel_valid;
    logic [CW-1:0] hrs_raw;

    assign sel_valid    = (32'(bus.alm_sel) < NA);
    assign hrs_raw      = (bus.alarmset && sel_valid) ? ahrs_all[bus.alm_sel] : hrs_reg;
    assign bus.disp_min = (bus.alarmset && sel_valid) ? amin_all[bus.alm_sel] : min_reg;

`ifdef TWELVE_HR_EN
    assign bus.disp_hrs = (hrs_raw == '0)         ? CW'(12) :
                          (hrs_raw > CW'(12))     ? hrs_raw - CW'(12) : hrs_raw;
    assign bus.pm       = (hrs_raw >= CW'(12));
`else
    assign bus.disp_hrs = hrs_raw;
    assign bus.pm       = 1'b0;
`endif

    assign bus.t_sec    = sec_reg;
    assign bus.t_min    = min_reg;
    assign bus.t_hrs    = hrs_reg;
    assign bus.t_day    = day_reg;
    assign bus.buzz     = buzz_reg;
    assign bus.snoozing = snoozing_reg;
    assign bus.ring_idx = idx_reg;
endmodule

// File: doc/alarm_clock_multi.md
Name: alarm_clock_multi

Overview:
Parametrised successor to the single-alarm digital clock core. It keeps seconds, minutes, hours and a day-of-week count. It holds NA independently settable alarm slots and runs a ring/snooze/timeout state machine. Outputs are binary fields only; 7-segment decoding stays in the existing lcd_int instances, which the top level drives from disp_* outputs.

Parameters:
NS, 60, seconds per minute and minutes per hour modulus
NH, 24, hours per day modulus
ND, 7, days per week modulus
NA, 2, number of alarm slots (>=1)
CW, 7, width of every time/alarm field
SNOOZE_SEC, 540, snooze duration in ticks
RING_SEC, 60, ticks of ringing before auto-stop

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
tick  in  1  one-cycle strobe, 1 per second
timeset  in  1  time-set mode
alarmset  in  1  alarm-set mode for slot alm_sel
alm_sel  in  max(1,$clog2(NA))  alarm slot being set/displayed
minadv  in  1  advance minutes on each tick while in a set mode
hrsadv  in  1  advance hours on each tick while in a set mode
dayadv  in  1  advance day on each tick while timeset
alm_en  in  NA  per-slot arm bit
alarm_on  in  1  master alarm enable
snooze  in  1  snooze button (level; rising edge acts)
t_sec, t_min, t_hrs, t_day  out  CW  current time
disp_min, disp_hrs  out  CW  display fields (alarm slot when alarmset, else time)
pm  out  1  PM indicator (see Optional Feature)
buzz  out  1  alarm sounding
ring_idx  out  max(1,$clog2(NA))  slot that caused current ring/snooze
snoozing  out  1  high in SNOOZE state

Behaviour:
- Reset (rst=0 at a clock edge): every time, alarm, counter and output field = 0; FSM=IDLE; buzz=0; snooze edge register=0.
- All counting is qualified by tick; nothing advances on cycles with tick=0.
- Normal running (timeset=0):
  - t_sec increments mod NS.
  - t_min increments when t_sec wraps.
  - t_hrs increments when t_sec and t_min both wrap.
  - t_day increments when all three wrap.
- timeset=1:
  - t_sec holds.
  - On tick: minadv advances t_min mod NS; hrsadv advances t_hrs mod NH; dayadv advances t_day mod ND.
  - Advances are independent and carries are suppressed (t_min 59->0 does not bump t_hrs).
- alarmset=1 with timeset=0:
  - Time runs normally.
  - On tick, minadv/hrsadv advance slot alm_sel's minutes/hours, same wrap rules.
  - alm_sel>=NA: no slot is written; display shows time.
- timeset and alarmset both 1: timeset wins; no alarm slot is modified.
- Match pulse sec_upd = tick delayed one cycle. On a sec_upd cycle, slot i matches if alarm_on, alm_en[i], t_sec==0, t_min==amin[i] and t_hrs==ahrs[i].
- FSM states IDLE, RINGING, SNOOZE:
  - IDLE -> RINGING on any match. ring_idx = lowest matching index; ring counter = RING_SEC.
  - RINGING, snooze rising edge -> SNOOZE; snooze counter = SNOOZE_SEC.
  - RINGING, on tick: ring counter decrements; when it reaches 0 on a tick -> IDLE.
  - SNOOZE, on tick: snooze counter decrements; when it reaches 0 -> RINGING; ring counter reloaded to RING_SEC; ring_idx kept.
  - alarm_on=0 in any state -> IDLE next edge (highest priority after reset).
  - Matches while RINGING/SNOOZE are ignored.
  - Deasserting alm_en[ring_idx] mid-ring does not stop the ring.
- buzz = (state==RINGING), registered. Latency: the tick at which time becomes hh:mm:00 is cycle N; buzz is high from cycle N+2.
- snoozing = (state==SNOOZE).
- Snooze edge held across a SNOOZE->RINGING transition does not re-snooze; a fresh rising edge is required.
- Reset mid-ring clears everything at that edge.

Optional Feature:
TWELVE_HR_EN
- Defined: disp_hrs shows 12-hour form (0->12, 1..12 unchanged, 13..23->1..11); pm=1 when the underlying hour >=12; internal counters stay 0..NH-1.
- Undefined: disp_hrs is the raw hour and pm is tied 0.

Test Plan:
- Reset, then 3600 ticks -> t_sec=0, t_min=0, t_hrs=1, t_day=0; time at 23:59:59 day 6 plus 1 tick -> 00:00:00, day 0.
- timeset=1, minadv=1, 61 ticks from t_min=0 -> t_min=1, t_hrs unchanged, t_sec unchanged.
- alarmset=1, alm_sel=1, set slot1 to 06:30; alm_en=2'b10, alarm_on=1; run time to 06:30:00 -> buzz high exactly 2 cycles after that tick, ring_idx=1.
- Ringing, snooze rising edge -> buzz=0, snoozing=1; after 540 ticks -> buzz=1 again; with no further input, after 60 more ticks -> buzz=0, state IDLE.
- Slots 0 and 1 both set to 07:00 and armed -> a single ring with ring_idx=0; alarm_on dropped mid-ring -> buzz=0 next edge.
- TWELVE_HR_EN defined, t_hrs=0 -> disp_hrs=12, pm=0; t_hrs=13 -> disp_hrs=1, pm=1.
